seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. It keeps the eight-op encoding (ADD/SUB/AND/OR/NOT/XOR/NAND/NOR) and widens the datapath to WIDTH bits. It adds status flags and a start/busy/done handshake, plus an iterative unsigned multiply that takes WIDTH cycles. It sits between the register file and the writeback stage of the teaching CPU datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  4  operation code, sampled with start
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse when result and flags are valid
result  output  WIDTH  low word of the result
result_hi  output  WIDTH  high word of the product (MUL only, else 0)
carry  output  1  carry out / no-borrow / product-high-nonzero
zero  output  1  result == 0 (and result_hi == 0 for MUL)
overflow  output  1  signed overflow (ADD/SUB only)
illegal  output  1  op was not a legal code

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high.
- Reset: every output is 0 and the FSM goes to IDLE. A reset during a multiply aborts it; no done pulse is produced.
- Op codes:
  - 0 ADD: a+b.
  - 1 SUB: a+~b+1.
  - 2 AND, 3 OR, 5 XOR, 6 NAND, 7 NOR: bitwise on a and b.
  - 4 NOT: ~a; b is ignored.
  - 8 MUL: unsigned a*b.
  - 9..15: illegal.
- FSM states: IDLE, MUL.
  - IDLE with start=1 and op!=8: compute in the same cycle and register all outputs. done=1 on the next cycle (latency 1). State stays IDLE.
  - IDLE with start=1 and op=8: latch a and b, clear the accumulator, load counter=WIDTH, set busy=1 next cycle, go to MUL.
  - MUL: each cycle, if multiplier LSB=1 add the multiplicand into the upper accumulator, then shift right one bit. Decrement the counter. When the counter reaches 0, register the product, drive busy=0, pulse done, and return to IDLE. done is asserted WIDTH+1 cycles after the start cycle; busy is high for exactly WIDTH cycles.
- Start while busy=1 is ignored. Operands and op changes have no effect.
- Start in the same cycle done is high (busy=0) is accepted normally, so back-to-back single-cycle ops give done every cycle.
- result, result_hi and the flags hold their values until the next accepted operation completes. done is high for exactly one cycle.
- Flags:
  - ADD: carry = carry out of bit WIDTH-1; overflow = operand signs equal and result sign different.
  - SUB: carry = 1 when a>=b unsigned (no borrow); overflow = operand signs differ and result sign differs from a.
  - Logic ops: carry=0, overflow=0.
  - MUL: carry = (result_hi != 0), overflow=0.
  - zero is evaluated on the full registered result.
- Illegal op: latency 1; result=0, result_hi=0, carry=0, overflow=0, zero=1, illegal=1. illegal=0 for every legal op.
- result_hi=0 for all non-MUL ops.
- Arithmetic is modulo 2^WIDTH. The product is exactly 2*WIDTH bits; no truncation.

Decomposition:
- Shared package seq_alu_pkg holds:
  - op code constants OP_ADD..OP_NOR, OP_MUL (4-bit);
  - state enum IDLE/MUL;
  - counter width function clog2(WIDTH+1).
- One sub-module, seq_alu_mul, is natural. It is the shift-add multiplier with load, step and finished signals, owning the accumulator and counter. The top level keeps the single-cycle datapath, flag logic and handshake.

Test Plan:
1. WIDTH=8, reset then ADD a=0xFF b=0x01 -> next cycle: done=1, result=0x00, carry=1, zero=1, overflow=0.
2. SUB a=0x80 b=0x01 -> result=0x7F, carry=1, overflow=1. Then SUB a=0x01 b=0x02 -> result=0xFF, carry=0, overflow=0.
3. MUL a=0xFF b=0xFF -> busy high 8 cycles, done on cycle 9, result=0x01, result_hi=0xFE, carry=1, zero=0. A start (ADD 1+1) asserted at cycle 3 is ignored; the outputs are unchanged by it.
4. MUL a=0x0C b=0x0A, assert reset at cycle 4 -> all outputs 0, no done pulse. A subsequent NOT a=0x0F -> result=0xF0 after 1 cycle.
5. Back-to-back: XOR 0xAA^0x55, then NOR 0x00,0x00, then op=0xC on consecutive cycles -> done on three consecutive cycles with results 0xFF, 0xFF, then 0x00 with illegal=1 and zero=1.
6. Parameter sweep WIDTH=2 and WIDTH=32: random ops checked against a reference model; MUL latency equals WIDTH+1 in each case.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared constants and helpers for the sequential ALU.
// Op codes keep the 4-bit ALU encoding, with MUL added at code 8.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    typedef enum logic [0:0] {
        IDLE = S_IDLE,
        MUL  = S_MUL
    } state_e;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the datapath and the ALU.
// The master drives the request; the slave answers with status and result.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output start, op, a, b,
        input  busy, done, result, result_hi,
        input  carry, zero, overflow, illegal
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, result_hi,
        output carry, zero, overflow, illegal
    );
endinterface

// File: rtl/seq_alu_mul.sv
// Shift-add unsigned multiplier, one multiplier bit per step.
// The multiplier sits in the low half of the accumulator and shifts out.
module seq_alu_mul
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               finished_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     sum;

    always_comb begin
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (acc_q[0]) begin
            sum = sum + {1'b0, mcand_q};
        end
        acc_d = {sum, acc_q[WIDTH-1:1]};
    end

    // prod_o is the post-step value, valid in the last step cycle
    assign prod_o     = acc_d;
    assign finished_o = step_i && (cnt_q == CW'(1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            mcand_q <= a_i;
            acc_q   <= {{WIDTH{1'b0}}, b_i};
            cnt_q   <= CW'(WIDTH);
        end else if (step_i && cnt_q != '0) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with flags, start/busy/done handshake and
// an iterative multiply; single-cycle ops complete with latency 1.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    state_e             state_q;
    logic               accept;
    logic               mul_go;
    logic               mul_fin;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   res_d;
    logic               c_d;
    logic               v_d;
    logic               ill_d;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   hi_q;
    logic               c_q;
    logic               z_q;
    logic               v_q;
    logic               ill_q;
    logic               done_q;

    assign accept = bus.start && (state_q == IDLE);
    assign mul_go = accept && (bus.op == OP_MUL);

    always_comb begin
        sum   = '0;
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        ill_d = 1'b0;
        unique case (1'b1)
            bus.op == OP_ADD: begin
                sum   = {1'b0, bus.a} + {1'b0, bus.b};
                res_d = sum[MSB:0];
                c_d   = sum[WIDTH];
                v_d   = (bus.a[MSB] == bus.b[MSB])
                     && (res_d[MSB] != bus.a[MSB]);
            end
            bus.op == OP_SUB: begin
                sum   = {1'b0, bus.a} + {1'b0, ~bus.b}
                      + {{WIDTH{1'b0}}, 1'b1};
                res_d = sum[MSB:0];
                c_d   = sum[WIDTH];
                v_d   = (bus.a[MSB] != bus.b[MSB])
                     && (res_d[MSB] != bus.a[MSB]);
            end
            bus.op == OP_AND:  res_d = bus.a & bus.b;
            bus.op == OP_OR:   res_d = bus.a | bus.b;
            bus.op == OP_NOT:  res_d = ~bus.a;
            bus.op == OP_XOR:  res_d = bus.a ^ bus.b;
            bus.op == OP_NAND: res_d = ~(bus.a & bus.b);
            bus.op == OP_NOR:  res_d = ~(bus.a | bus.b);
            bus.op == OP_MUL:  res_d = '0;
            default:           ill_d = 1'b1;
        endcase
    end

    seq_alu_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (mul_go),
        .step_i     (state_q == MUL),
        .a_i        (bus.a),
        .b_i        (bus.b),
        .finished_o (mul_fin),
        .prod_o     (prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == MUL) begin
                if (mul_fin) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    res_q   <= prod[MSB:0];
                    hi_q    <= prod[2*WIDTH-1:WIDTH];
                    c_q     <= |prod[2*WIDTH-1:WIDTH];
                    z_q     <= (prod == '0);
                    v_q     <= 1'b0;
                    ill_q   <= 1'b0;
                end
            end else if (accept) begin
                if (mul_go) begin
                    state_q <= MUL;
                end else begin
                    done_q <= 1'b1;
                    res_q  <= res_d;
                    hi_q   <= '0;
                    c_q    <= c_d;
                    z_q    <= (res_d == '0);
                    v_q    <= v_d;
                    ill_q  <= ill_d;
                end
            end
        end
    end

    assign bus.busy      = (state_q == MUL);
    assign bus.done      = done_q;
    assign bus.result    = res_q;
    assign bus.result_hi = hi_q;
    assign bus.carry     = c_q;
    assign bus.zero      = z_q;
    assign bus.overflow  = v_q;
    assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed WIDTH=8 vectors and sequences, plus
// random ops at WIDTH 2, 8 and 32 against an arithmetic model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic [63:0] hi;
        logic        c;
        logic        z;
        logic        v;
        logic        ill;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [7:0] hi;
        logic       c;
        logic       z;
        logic       v;
        logic       ill;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst8;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(8)) b8 ();

    seq_alu #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .reset (rst8),
        .bus   (b8)
    );

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic longint sgn(input int w, input logic [63:0] x);
        if (x[w-1]) return longint'(x) - (longint'(1) << w);
        return longint'(x);
    endfunction

    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
        exp_t        e;
        logic [63:0] m;
        logic [63:0] full;
        longint      s;
        longint      smax;
        longint      smin;
        m     = (64'd1 << w) - 64'd1;
        smax  = (longint'(1) << (w - 1)) - 1;
        smin  = -(longint'(1) << (w - 1));
        e.res = '0;
        e.hi  = '0;
        e.c   = 1'b0;
        e.v   = 1'b0;
        e.ill = 1'b0;
        e.lat = 1;
        case (op)
            OP_ADD: begin
                full  = a + b;
                e.res = full & m;
                e.c   = full[w];
                s     = sgn(w, a) + sgn(w, b);
                e.v   = (s > smax) || (s < smin);
            end
            OP_SUB: begin
                e.res = (a - b) & m;
                e.c   = (a >= b);
                s     = sgn(w, a) - sgn(w, b);
                e.v   = (s > smax) || (s < smin);
            end
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_NOT:  e.res = ~a & m;
            OP_XOR:  e.res = a ^ b;
            OP_NAND: e.res = ~(a & b) & m;
            OP_NOR:  e.res = ~(a | b) & m;
            OP_MUL: begin
                full  = a * b;
                e.res = full & m;
                e.hi  = full >> w;
                e.c   = (e.hi != 0);
                e.lat = w + 1;
            end
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 0) && (e.hi == 0);
        return e;
    endfunction

    task automatic run8(input logic [3:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        output int lat, output int bc);
        @(negedge clk);
        b8.start = 1'b1;
        b8.op    = op;
        b8.a     = a;
        b8.b     = b;
        lat = 0;
        bc  = 0;
        do begin
            @(negedge clk);
            b8.start = 1'b0;
            lat++;
            if (b8.busy) bc++;
        end while (!b8.done && lat < 64);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int W = (g == 0) ? 2 : (g == 1) ? 8 : 32;
        logic rst;
        bit   fin;
        seq_alu_if #(.WIDTH(W)) bus ();

        seq_alu #(.WIDTH(W)) dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus)
        );

        initial begin
            exp_t       e;
            int         lat;
            int         bc;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [3:0]   rop;
            rst       = 1'b1;
            bus.start = 1'b0;
            bus.op    = '0;
            bus.a     = '0;
            bus.b     = '0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 60; k++) begin
                rop = (k % 3 == 0) ? OP_MUL : 4'($urandom_range(0, 15));
                ra  = W'($urandom);
                rb  = W'($urandom);
                if (k % 5 == 1) begin
                    ra = '1;
                    rb = '1;
                end
                e = model(W, rop, 64'(ra), 64'(rb));
                @(negedge clk);
                bus.start = 1'b1;
                bus.op    = rop;
                bus.a     = ra;
                bus.b     = rb;
                lat = 0;
                bc  = 0;
                do begin
                    @(negedge clk);
                    bus.start = 1'b0;
                    lat++;
                    if (bus.busy) bc++;
                end while (!bus.done && lat < 100);
                check($sformatf("w%0d op%0d lat", W, rop), lat, e.lat);
                check($sformatf("w%0d op%0d busy", W, rop), bc, e.lat - 1);
                check($sformatf("w%0d op%0d res", W, rop),
                      bus.result, e.res);
                check($sformatf("w%0d op%0d hi", W, rop),
                      bus.result_hi, e.hi);
                check($sformatf("w%0d op%0d flags", W, rop),
                      {bus.carry, bus.zero, bus.overflow, bus.illegal},
                      {e.c, e.z, e.v, e.ill});
            end
            fin = 1'b1;
        end
    end

    initial begin
        vec_t tbl[12];
        int   lat;
        int   bc;
        int   nd;
        rst8     = 1'b1;
        b8.start = 1'b0;
        b8.op    = '0;
        b8.a     = '0;
        b8.b     = '0;
        repeat (3) @(negedge clk);
        check("reset result", {b8.result_hi, b8.result}, 0);
        check("reset status",
              {b8.busy, b8.done, b8.carry, b8.zero,
               b8.overflow, b8.illegal}, 0);
        rst8 = 1'b0;

        //         op       a      b      res    hi     c  z  v  il lat
        tbl[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 1, 0, 0, 1};
        tbl[1]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 1, 0, 1, 0, 1};
        tbl[2]  = '{OP_SUB, 8'h01, 8'h02, 8'hFF, 8'h00, 0, 0, 0, 0, 1};
        tbl[3]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 0, 0, 1, 0, 1};
        tbl[4]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 0, 1};
        tbl[5]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 8'h00, 0, 0, 0, 0, 1};
        tbl[6]  = '{OP_NAND, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 1, 0, 0, 1};
        tbl[7]  = '{OP_NOT, 8'h0F, 8'hAA, 8'hF0, 8'h00, 0, 0, 0, 0, 1};
        tbl[8]  = '{OP_MUL, 8'h0C, 8'h0A, 8'h78, 8'h00, 0, 0, 0, 0, 9};
        tbl[9]  = '{OP_MUL, 8'h00, 8'h37, 8'h00, 8'h00, 0, 1, 0, 0, 9};
        tbl[10] = '{4'hF,   8'h12, 8'h34, 8'h00, 8'h00, 0, 1, 0, 1, 1};
        tbl[11] = '{OP_SUB, 8'h05, 8'h05, 8'h00, 8'h00, 1, 1, 0, 0, 1};

        for (int i = 0; i < 12; i++) begin
            run8(tbl[i].op, tbl[i].a, tbl[i].b, lat, bc);
            check($sformatf("v%0d lat", i), lat, tbl[i].lat);
            check($sformatf("v%0d busy", i), bc, tbl[i].lat - 1);
            check($sformatf("v%0d res", i), b8.result, tbl[i].res);
            check($sformatf("v%0d hi", i), b8.result_hi, tbl[i].hi);
            check($sformatf("v%0d flags", i),
                  {b8.carry, b8.zero, b8.overflow, b8.illegal},
                  {tbl[i].c, tbl[i].z, tbl[i].v, tbl[i].ill});
        end

        // MUL with an ADD request landing mid-multiply
        @(negedge clk);
        b8.start = 1'b1;
        b8.op    = OP_MUL;
        b8.a     = 8'hFF;
        b8.b     = 8'hFF;
        lat = 0;
        bc  = 0;
        nd  = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (b8.busy) bc++;
            if (b8.done) begin
                nd++;
                if (lat == 0) lat = c;
            end
            b8.start = (c == 3);
            if (c == 3) begin
                b8.op = OP_ADD;
                b8.a  = 8'h01;
                b8.b  = 8'h01;
            end
        end
        check("mul ff lat", lat, 9);
        check("mul ff busy", bc, 8);
        check("mul ff done count", nd, 1);
        check("mul ff res", {b8.result_hi, b8.result}, 16'hFE01);
        check("mul ff flags",
              {b8.carry, b8.zero, b8.overflow, b8.illegal}, 4'b1000);

        // reset during a multiply
        @(negedge clk);
        b8.start = 1'b1;
        b8.op    = OP_MUL;
        b8.a     = 8'h0C;
        b8.b     = 8'h0A;
        nd = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            b8.start = 1'b0;
            rst8 = (c == 4);
            if (b8.done) nd++;
        end
        check("abort done count", nd, 0);
        check("abort result", {b8.result_hi, b8.result}, 0);
        check("abort status",
              {b8.busy, b8.done, b8.carry, b8.zero,
               b8.overflow, b8.illegal}, 0);
        run8(OP_NOT, 8'h0F, 8'h00, lat, bc);
        check("not after abort lat", lat, 1);
        check("not after abort res", b8.result, 8'hF0);

        // back-to-back single-cycle ops
        @(negedge clk);
        b8.start = 1'b1;
        b8.op    = OP_XOR;
        b8.a     = 8'hAA;
        b8.b     = 8'h55;
        @(negedge clk);
        check("b2b xor", {b8.done, b8.result}, 9'h1FF);
        b8.op = OP_NOR;
        b8.a  = 8'h00;
        b8.b  = 8'h00;
        @(negedge clk);
        check("b2b nor", {b8.done, b8.result}, 9'h1FF);
        b8.op = 4'hC;
        @(negedge clk);
        b8.start = 1'b0;
        check("b2b illegal",
              {b8.done, b8.result, b8.illegal, b8.zero}, 11'h403);
        @(negedge clk);
        check("b2b done drops", b8.done, 1'b0);

        for (int t = 0; t < 8000; t++) begin
            if (g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin) break;
            @(negedge clk);
        end
        check("random streams finished",
              {g_rnd[0].fin, g_rnd[1].fin, g_rnd[2].fin}, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
